// File: rtl/axis_fifo.sv
// AXI4-Stream first-word-fall-through FIFO carrying tdata and tlast per beat.
// Reports its occupancy and gives a pulse for each packet that completes on the m side.
module axis_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  pkt_done
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  pkt_done_q, pkt_done_d;
   logic [DATA_WIDTH:0]   head;
   logic                  push, pop;

   // Flags come from the registered count only, so no ready/valid input reaches them combinationally.
   assign s_tready = areset_n & (count_q != FULL);
   assign m_tvalid = (count_q != '0);
   assign push     = s_tvalid & s_tready;
   assign pop      = m_tvalid & m_tready;

   assign head     = mem_q[rd_ptr_q];
   assign m_tdata  = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
   assign m_tlast  = m_tvalid & head[DATA_WIDTH];
   assign count    = count_q;
   assign pkt_done = pkt_done_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pkt_done_d = pop & m_tlast;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   // Storage is not reset; the output gating keeps unwritten slots off the bus.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
   end

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: directed vector table, reset sequence, randomized scoreboard.
// Inputs change 1 time unit after the rising edge and outputs are sampled there or on the falling edge.
module tb_axis_fifo;

   logic        aclk;
   logic        areset_n;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] s_tdata;
   logic        s_tlast;
   logic        m_tvalid;
   logic        m_tready;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic [2:0]  count;
   logic        pkt_done;

   int checks = 0;
   int errors = 0;

   axis_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
      .aclk(aclk), .areset_n(areset_n),
      .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tdata(s_tdata), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tdata(m_tdata), .m_tlast(m_tlast),
      .count(count), .pkt_done(pkt_done)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic        sv;
      logic [31:0] sd;
      logic        sl;
      logic        mr;
      logic        e_sr;
      logic        e_mv;
      logic [31:0] e_md;
      logic        e_ml;
      logic [2:0]  e_cnt;
      logic        e_pd;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic sv, input logic [31:0] sd, input logic sl,
                      input logic mr, input logic e_sr, input logic e_mv,
                      input logic [31:0] e_md, input logic e_ml,
                      input logic [2:0] e_cnt, input logic e_pd);
      vec_t v;
      v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
      v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md;
      v.e_ml = e_ml; v.e_cnt = e_cnt; v.e_pd = e_pd;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic [31:0] sd,
                        input logic sl, input logic mr);
      s_tvalid = sv; s_tdata = sd; s_tlast = sl; m_tready = mr;
   endtask

   logic [32:0] beats [20];
   int tx, rx, pulses, cyc;
   logic hold, push, pop, exp_pd;

   initial begin
      areset_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("reset_state", {61'h0, s_tready, m_tvalid, pkt_done}, 64'h0);
      chk("reset_count_data", {28'h0, m_tdata, count, m_tlast}, 64'h0);
      @(negedge aclk);
      @(negedge aclk);
      areset_n = 1'b1;
      #1;
      chk("release_s_tready", {63'h0, s_tready}, 64'h1);
      @(posedge aclk);
      #1;

      // Single beat with tlast
      add(1, 32'haaaa_bbbb, 1, 1,  1, 1, 32'haaaa_bbbb, 1, 3'd1, 0);
      add(0, 32'h0, 0, 1,          1, 0, 32'h0, 0, 3'd0, 1);
      add(0, 32'h0, 0, 1,          1, 0, 32'h0, 0, 3'd0, 0);
      // Fill with m_tready low, offer a fifth beat, then drain
      add(1, 32'h1, 0, 0,          1, 1, 32'h1, 0, 3'd1, 0);
      add(1, 32'h2, 0, 0,          1, 1, 32'h1, 0, 3'd2, 0);
      add(1, 32'h3, 0, 0,          1, 1, 32'h1, 0, 3'd3, 0);
      add(1, 32'h4, 0, 0,          0, 1, 32'h1, 0, 3'd4, 0);
      add(1, 32'h5, 0, 0,          0, 1, 32'h1, 0, 3'd4, 0);
      add(0, 32'h0, 0, 1,          1, 1, 32'h2, 0, 3'd3, 0);
      add(0, 32'h0, 0, 1,          1, 1, 32'h3, 0, 3'd2, 0);
      add(0, 32'h0, 0, 1,          1, 1, 32'h4, 0, 3'd1, 0);
      add(0, 32'h0, 0, 1,          1, 0, 32'h0, 0, 3'd0, 0);
      // Streaming, one beat per cycle
      add(1, 32'hcccc_dd00, 0, 1,  1, 1, 32'hcccc_dd00, 0, 3'd1, 0);
      for (int i = 1; i < 8; i++)
         add(1, 32'hcccc_dd00 + i, i == 7, 1,
             1, 1, 32'hcccc_dd00 + i, i == 7, 3'd1, 0);
      add(0, 32'h0, 0, 1,          1, 0, 32'h0, 0, 3'd0, 1);
      add(0, 32'h0, 0, 1,          1, 0, 32'h0, 0, 3'd0, 0);
      // Full boundary: push refused while popping, then push+pop at count 3
      add(1, 32'h10, 0, 0,         1, 1, 32'h10, 0, 3'd1, 0);
      add(1, 32'h11, 0, 0,         1, 1, 32'h10, 0, 3'd2, 0);
      add(1, 32'h12, 0, 0,         1, 1, 32'h10, 0, 3'd3, 0);
      add(1, 32'h13, 0, 0,         0, 1, 32'h10, 0, 3'd4, 0);
      add(1, 32'h14, 0, 1,         1, 1, 32'h11, 0, 3'd3, 0);
      add(1, 32'h15, 0, 1,         1, 1, 32'h12, 0, 3'd3, 0);
      add(0, 32'h0, 0, 1,          1, 1, 32'h13, 0, 3'd2, 0);
      add(0, 32'h0, 0, 1,          1, 1, 32'h15, 0, 3'd1, 0);
      add(0, 32'h0, 0, 1,          1, 0, 32'h0, 0, 3'd0, 0);

      foreach (vq[i]) begin
         drive(vq[i].sv, vq[i].sd, vq[i].sl, vq[i].mr);
         @(posedge aclk);
         #1;
         chk($sformatf("vec%0d {sr,mv,md,ml,cnt,pd}", i),
             {25'h0, s_tready, m_tvalid, m_tdata, m_tlast, count, pkt_done},
             {25'h0, vq[i].e_sr, vq[i].e_mv, vq[i].e_md, vq[i].e_ml,
              vq[i].e_cnt, vq[i].e_pd});
      end

      // Asynchronous reset with two beats held
      drive(1, 32'h21, 0, 0);
      @(posedge aclk); #1;
      drive(1, 32'h22, 0, 0);
      @(posedge aclk); #1;
      drive(0, 32'h0, 0, 0);
      chk("hold_two", {61'h0, count}, 64'd2);
      @(negedge aclk);
      #2;
      areset_n = 1'b0;
      #1;
      chk("async_reset", {26'h0, count, m_tvalid, m_tdata, s_tready},
          64'h0);
      @(posedge aclk);
      @(negedge aclk);
      areset_n = 1'b1;
      #1;
      chk("reset_release_empty", {60'h0, count, m_tvalid}, 64'h0);
      @(posedge aclk); #1;
      drive(1, 32'hdead_beef, 0, 0);
      @(posedge aclk); #1;
      drive(0, 32'h0, 0, 1);
      chk("first_after_reset", {29'h0, count, m_tdata}, {29'h0, 3'd1, 32'hdead_beef});
      @(posedge aclk); #1;
      chk("drained_after_reset", {61'h0, count}, 64'h0);

      // Random handshakes, 20 beats in packets of 7, 6, 7
      for (int i = 0; i < 20; i++)
         beats[i] = {(i == 6 || i == 12 || i == 19), 32'h5000_0000 + 32'(i * 3)};
      tx = 0; rx = 0; pulses = 0; cyc = 0; hold = 1'b0;
      while (rx < 20 && cyc < 2000) begin
         cyc++;
         s_tvalid = (tx < 20) && (hold || ($urandom % 2 == 1));
         s_tdata  = (tx < 20) ? beats[tx][31:0] : 32'h0;
         s_tlast  = (tx < 20) ? beats[tx][32] : 1'b0;
         m_tready = ($urandom % 2 == 1);
         @(negedge aclk);
         push = s_tvalid & s_tready;
         pop  = m_tvalid & m_tready;
         exp_pd = pop & beats[rx][32];
         if (pop)
            chk($sformatf("rand_beat%0d", rx), {31'h0, m_tlast, m_tdata},
                {31'h0, beats[rx]});
         @(posedge aclk);
         #1;
         hold = s_tvalid & !push;
         if (push) tx++;
         if (pop) rx++;
         if (pkt_done) pulses++;
         if (pkt_done !== exp_pd || count !== 3'(tx - rx) || count > 3'd4) begin
            chk("rand_cycle {pd,cnt}", {60'h0, pkt_done, count},
                {60'h0, exp_pd, 3'(tx - rx)});
         end
      end
      drive(0, 32'h0, 0, 0);
      chk("rand_all_received", 64'(rx), 64'd20);
      chk("rand_pkt_pulses", 64'(pulses), 64'd3);
      chk("rand_final_count", {61'h0, count}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Synchronous AXI4-Stream FIFO. It sits between the AXI-Stream master stage and the AXI-Stream slave stage.
- Decouples producer and consumer timing and absorbs backpressure bursts up to DEPTH beats.
- Carries tdata and tlast together per beat. Reports occupancy and completed packets.

Parameters:
- DATA_WIDTH, 32, width of tdata.
- ADDR_WIDTH, 2, log2 of FIFO depth. DEPTH = 2**ADDR_WIDTH, so the default is 4. ADDR_WIDTH must be >= 1.

Ports:
- aclk  input  1  single clock. All logic is on the rising edge.
- areset_n  input  1  asynchronous, active-low reset.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  FIFO can accept a beat.
- s_tdata  input  DATA_WIDTH  upstream data.
- s_tlast  input  1  upstream last beat of packet.
- m_tvalid  output  1  FIFO holds a beat for downstream.
- m_tready  input  1  downstream accepts a beat.
- m_tdata  output  DATA_WIDTH  head-of-FIFO data.
- m_tlast  output  1  head-of-FIFO tlast.
- count  output  ADDR_WIDTH+1  number of beats stored, 0..DEPTH.
- pkt_done  output  1  one-cycle pulse, registered, after a beat with tlast leaves on the m side.

Behaviour:
- Reset:
  - Asserting areset_n low immediately clears wr_ptr, rd_ptr, count and pkt_done, and forces m_tvalid to 0.
  - s_tready is 0 while areset_n is low and goes to 1 on release, since the FIFO is empty.
  - Storage array is not reset.
  - m_tdata and m_tlast are gated to 0 whenever m_tvalid is 0, so outputs never carry X.
- Handshakes:
  - push = s_tvalid & s_tready.
  - pop = m_tvalid & m_tready.
  - A transfer completes only on a rising edge with both valid and ready high.
- Flags:
  - s_tready = areset_n & (count != DEPTH).
  - m_tvalid = (count != 0).
  - Both derive from registered count only. There is no combinational path from s_tvalid to m_tvalid, from m_tready to s_tready, or from s_tvalid to s_tready.
- Data path:
  - First-word-fall-through. m_tdata/m_tlast = mem[rd_ptr] when m_tvalid is 1.
  - Latency: a beat pushed at edge N is presented on the m side immediately after edge N. Minimum one cycle, with zero bubbles.
- Count update:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged, wr_ptr and rd_ptr both advance.
  - neither: hold.
- Pointers:
  - ADDR_WIDTH bits each, incrementing modulo DEPTH.
  - Wrap from DEPTH-1 to 0 needs no special case.
- Full boundary:
  - When count == DEPTH, s_tready is 0 and s_* inputs are ignored.
  - A pop in that cycle makes s_tready 1 in the next cycle. There is no same-cycle pass-through.
- Empty boundary:
  - When count == 0, m_tvalid is 0 and m_tready is ignored.
  - A push in that cycle makes m_tvalid 1 in the next cycle.
- AXI stability: while m_tvalid & !m_tready, m_tdata and m_tlast hold stable, because rd_ptr does not move and pushes write other slots.
- Throughput: with s_tvalid and m_tready held high, one beat per cycle is sustained indefinitely at any count below DEPTH.
- pkt_done: registered 1 in the cycle after an edge where pop & m_tlast; 0 otherwise.
- Ordering: beats leave in exact arrival order. tlast stays attached to its beat.
- Reset mid-operation: all stored beats are discarded. After release the FIFO behaves as freshly reset, and no stale beat is ever presented.

Test Plan:
1. Empty FIFO, m_tready=1. Push one beat 32'haaaa_bbbb with tlast=1.
   -> m_tvalid=1, m_tdata=32'haaaa_bbbb, m_tlast=1 immediately after the push edge.
   -> count goes 1 then 0; pkt_done pulses exactly once, one cycle after the pop.
2. m_tready=0. Push 32'h1, 32'h2, 32'h3, 32'h4 back-to-back, then offer 32'h5.
   -> count=4, s_tready=0, 32'h5 not accepted.
   -> Raise m_tready: output 1,2,3,4 in order; s_tready=1 one cycle after the first pop; count falls to 0.
3. s_tvalid and m_tready held high. Stream 8 beats 32'hcccc_dd00..07, tlast on the last.
   -> One beat per cycle with no gaps, order preserved, count stable at 1, one pkt_done pulse.
4. Random s_tvalid/m_tready (50%). Send 20 beats, 3 packets.
   -> Scoreboard matches data and tlast exactly across multiple pointer wraps.
   -> Exactly 3 pkt_done pulses; count never exceeds 4.
5. Hold 2 beats (count=2), then pulse areset_n low mid-cycle.
   -> count=0, m_tvalid=0, m_tdata=0, s_tready=0 asynchronously.
   -> After release, push 32'hdead_beef: it is the first beat out.
6. Full FIFO (count=4). Push and pop attempted in the same cycle.
   -> Pop occurs, push is refused, count=3.
   -> At count=3, simultaneous push and pop leaves count=3 with both pointers advanced.
